// File: rtl/weight_sram_ctrl.sv
// ---------------------------------------------------------------------------
// weight_sram_ctrl
// Shares the weight SRAM's single address port between a DMA load job
// (sequential 32-bit word writes) and PE-array tile fetches (reads).
// All SRAM control inputs are registered. Fetches normally win the port;
// a waiting load word is forced through after MAX_STARVE consecutive
// fetch grants.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   cfg_start/base/len       load job start pulse, first word address, length
//   load_busy, load_done     job in progress, one-cycle completion pulse
//   ld_valid/ready, ld_data  load word handshake
//   fr_valid/ready           fetch request handshake
//   fr_tile/half/lane        fetch address fields -> {tile, half, lane}
//   w_valid                  SRAM DO holds data for a granted fetch
//   sram_addr/en/we/di       registered SRAM controls
//
// state | meaning
// IDLE  | no job, waiting for cfg_start
// LOAD  | job active, writing words as they arrive
// DONE  | job finished, load_done high for this cycle
// ---------------------------------------------------------------------------
module weight_sram_ctrl #(
   parameter int MAX_STARVE = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        cfg_start,
   input  logic [11:0] cfg_base,
   input  logic [12:0] cfg_len,
   output logic        load_busy,
   output logic        load_done,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_data,
   input  logic        fr_valid,
   output logic        fr_ready,
   input  logic [8:0]  fr_tile,
   input  logic        fr_half,
   input  logic [1:0]  fr_lane,
   output logic        w_valid,
   output logic [11:0] sram_addr,
   output logic        sram_en,
   output logic        sram_we,
   output logic [31:0] sram_di
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

   state_t      state;
   logic [11:0] ptr;
   logic [12:0] remain;
   logic [3:0]  scnt;

   logic in_load;
   logic starved;
   logic ld_pending;
   logic ld_hs;
   logic fr_hs;

   assign in_load    = (state == LOAD);
   assign starved    = (scnt == STARVE_MAX);
   assign ld_pending = in_load & ld_valid;

   assign ld_ready = in_load & (~fr_valid | starved);
   assign fr_ready = ~(ld_pending & starved);
   assign ld_hs    = ld_valid & ld_ready;
   assign fr_hs    = fr_valid & fr_ready;

   assign load_busy = (state != IDLE);
   assign load_done = (state == DONE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         ptr       <= 12'd0;
         remain    <= 13'd0;
         scnt      <= 4'd0;
         sram_addr <= 12'd0;
         sram_en   <= 1'b0;
         sram_we   <= 1'b0;
         sram_di   <= 32'd0;
         w_valid   <= 1'b0;
      end else begin
         // ld_ready and fr_ready are mutually exclusive whenever both
         // requesters are valid, so at most one of these is set.
         sram_en <= fr_hs;
         sram_we <= ld_hs;
         w_valid <= sram_en;

         if (fr_hs) begin
            sram_addr <= {fr_tile, fr_half, fr_lane};
         end else if (ld_hs) begin
            sram_addr <= ptr;
            sram_di   <= ld_data;
         end

         // Counts fetch grants that overtook a waiting load word.
         if (ld_hs || !ld_pending) begin
            scnt <= 4'd0;
         end else if (fr_hs && !starved) begin
            scnt <= scnt + 4'd1;
         end

         case (state)
            IDLE: begin
               if (cfg_start) begin
                  ptr    <= cfg_base;
                  remain <= cfg_len;
                  state  <= (cfg_len == 13'd0) ? DONE : LOAD;
               end
            end
            LOAD: begin
               if (ld_hs) begin
                  ptr    <= ptr + 12'd1;
                  remain <= remain - 13'd1;
                  if (remain == 13'd1) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
